// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the instruction/data cache controllers, the arbiter
// and the shared backing memory port.
// slave  : arbiter view (requests and memory results in, ready/data/commands out)
// master : environment view (cache controllers plus memory model)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Instruction side
  logic              i_ren;
  logic [ADDR_W-1:0] i_address;
  logic              i_ready;
  logic [DATA_W-1:0] i_dataout;
  // Data side
  logic              d_ren;
  logic              d_wen;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_datain;
  logic [3:0]        d_byte_select;
  logic              d_ready;
  logic [DATA_W-1:0] d_dataout;
  // Memory port
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_datain;
  logic [3:0]        mem_byte_select;
  logic [DATA_W-1:0] mem_dataout;
  logic              mem_memsig;

  modport slave (
    input  i_ren, i_address,
    output i_ready, i_dataout,
    input  d_ren, d_wen, d_address, d_datain, d_byte_select,
    output d_ready, d_dataout,
    output mem_ren, mem_wen, mem_address, mem_datain, mem_byte_select,
    input  mem_dataout, mem_memsig
  );

  modport master (
    output i_ren, i_address,
    input  i_ready, i_dataout,
    output d_ren, d_wen, d_address, d_datain, d_byte_select,
    input  d_ready, d_dataout,
    input  mem_ren, mem_wen, mem_address, mem_datain, mem_byte_select,
    output mem_dataout, mem_memsig
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the instruction-side
// and data-side cache controllers. Registered memory commands; one-cycle
// ready pulse per consumed request; a RESP cycle separates grants.
// Optional watchdog abort enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic                err
);

  // Reject a watchdog limit that could never be reached
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
  typedef enum logic {SIDE_I, SIDE_D} side_t;

  state_t            r_state, w_state_nxt;
  side_t             r_last, w_last_nxt;
  logic              r_i_ready, w_i_ready_nxt;
  logic              r_d_ready, w_d_ready_nxt;
  logic [DATA_W-1:0] r_i_dataout, w_i_dataout_nxt;
  logic [DATA_W-1:0] r_d_dataout, w_d_dataout_nxt;
  logic              r_mem_ren, w_mem_ren_nxt;
  logic              r_mem_wen, w_mem_wen_nxt;
  logic [ADDR_W-1:0] r_mem_address, w_mem_address_nxt;
  logic [DATA_W-1:0] r_mem_datain, w_mem_datain_nxt;
  logic [3:0]        r_mem_byte_select, w_mem_byte_select_nxt;

  logic w_i_pend, w_d_pend, w_grant_d, w_grant_i;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_wdog, w_wdog_nxt;
  logic             r_err, w_err_nxt;
  logic             w_wdog_hit;

  // Watchdog expires on the BUSY cycle that would bring the count to the limit
  assign w_wdog_hit = (32'(r_wdog) + 32'd1) >= TIMEOUT_CYCLES;
  assign err        = r_err;
`else
  assign err = 1'b0;
`endif

  // Pending requests and round-robin tie break (side other than last grant wins)
  assign w_i_pend  = bus.i_ren;
  assign w_d_pend  = bus.d_ren | bus.d_wen;
  assign w_grant_d = w_d_pend & (~w_i_pend | (r_last == SIDE_I));
  assign w_grant_i = w_i_pend & ~w_grant_d;

  assign bus.i_ready         = r_i_ready;
  assign bus.d_ready         = r_d_ready;
  assign bus.i_dataout       = r_i_dataout;
  assign bus.d_dataout       = r_d_dataout;
  assign bus.mem_ren         = r_mem_ren;
  assign bus.mem_wen         = r_mem_wen;
  assign bus.mem_address     = r_mem_address;
  assign bus.mem_datain      = r_mem_datain;
  assign bus.mem_byte_select = r_mem_byte_select;

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state           <= IDLE;
      r_last            <= SIDE_I;
      r_i_ready         <= 1'b0;
      r_d_ready         <= 1'b0;
      r_i_dataout       <= '0;
      r_d_dataout       <= '0;
      r_mem_ren         <= 1'b0;
      r_mem_wen         <= 1'b0;
      r_mem_address     <= '0;
      r_mem_datain      <= '0;
      r_mem_byte_select <= 4'h0;
`ifdef ARB_TIMEOUT_EN
      r_wdog            <= '0;
      r_err             <= 1'b0;
`endif
    end else begin
      r_state           <= w_state_nxt;
      r_last            <= w_last_nxt;
      r_i_ready         <= w_i_ready_nxt;
      r_d_ready         <= w_d_ready_nxt;
      r_i_dataout       <= w_i_dataout_nxt;
      r_d_dataout       <= w_d_dataout_nxt;
      r_mem_ren         <= w_mem_ren_nxt;
      r_mem_wen         <= w_mem_wen_nxt;
      r_mem_address     <= w_mem_address_nxt;
      r_mem_datain      <= w_mem_datain_nxt;
      r_mem_byte_select <= w_mem_byte_select_nxt;
`ifdef ARB_TIMEOUT_EN
      r_wdog            <= w_wdog_nxt;
      r_err             <= w_err_nxt;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt           = r_state;
    w_last_nxt            = r_last;
    w_i_ready_nxt         = 1'b0;
    w_d_ready_nxt         = 1'b0;
    w_i_dataout_nxt       = r_i_dataout;
    w_d_dataout_nxt       = r_d_dataout;
    w_mem_ren_nxt         = r_mem_ren;
    w_mem_wen_nxt         = r_mem_wen;
    w_mem_address_nxt     = r_mem_address;
    w_mem_datain_nxt      = r_mem_datain;
    w_mem_byte_select_nxt = r_mem_byte_select;
`ifdef ARB_TIMEOUT_EN
    w_wdog_nxt            = r_wdog;
    w_err_nxt             = 1'b0;
`endif

    unique case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_state_nxt       = BUSY_D;
          w_last_nxt        = SIDE_D;
          w_mem_address_nxt = bus.d_address;
          w_mem_byte_select_nxt = bus.d_byte_select;
          if (bus.d_wen) begin
            w_mem_wen_nxt    = 1'b1;
            w_mem_ren_nxt    = 1'b0;
            w_mem_datain_nxt = bus.d_datain;
          end else begin
            w_mem_wen_nxt    = 1'b0;
            w_mem_ren_nxt    = 1'b1;
          end
`ifdef ARB_TIMEOUT_EN
          w_wdog_nxt = '0;
`endif
        end else if (w_grant_i) begin
          w_state_nxt           = BUSY_I;
          w_last_nxt            = SIDE_I;
          w_mem_address_nxt     = bus.i_address;
          w_mem_byte_select_nxt = 4'hF;
          w_mem_ren_nxt         = 1'b1;
          w_mem_wen_nxt         = 1'b0;
`ifdef ARB_TIMEOUT_EN
          w_wdog_nxt = '0;
`endif
        end
      end
      BUSY_I: begin
        if (bus.mem_memsig) begin
          w_mem_ren_nxt   = 1'b0;
          w_mem_wen_nxt   = 1'b0;
          w_i_dataout_nxt = bus.mem_dataout;
          w_i_ready_nxt   = 1'b1;
          w_state_nxt     = RESP;
        end
`ifdef ARB_TIMEOUT_EN
        else if (w_wdog_hit) begin
          w_mem_ren_nxt = 1'b0;
          w_mem_wen_nxt = 1'b0;
          w_i_ready_nxt = 1'b1;
          w_err_nxt     = 1'b1;
          w_state_nxt   = RESP;
        end else begin
          w_wdog_nxt = r_wdog + CNT_W'(1);
        end
`endif
      end
      BUSY_D: begin
        if (bus.mem_memsig) begin
          w_mem_ren_nxt = 1'b0;
          w_mem_wen_nxt = 1'b0;
          if (!r_mem_wen) begin
            w_d_dataout_nxt = bus.mem_dataout;
          end
          w_d_ready_nxt = 1'b1;
          w_state_nxt   = RESP;
        end
`ifdef ARB_TIMEOUT_EN
        else if (w_wdog_hit) begin
          w_mem_ren_nxt = 1'b0;
          w_mem_wen_nxt = 1'b0;
          w_d_ready_nxt = 1'b1;
          w_err_nxt     = 1'b1;
          w_state_nxt   = RESP;
        end else begin
          w_wdog_nxt = r_wdog + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single reads, round-robin ties,
// writes, spurious completions, mid-transaction reset and (with
// ARB_TIMEOUT_EN) the watchdog abort.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TO_CYC = 4;
`else
  localparam int unsigned TO_CYC = 255;
`endif

  logic clk;
  logic reset;
  logic err;
  int   checks;
  int   failures;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".i_ready"}, 32'(bus.i_ready), 32'h0);
    chk({tag, ".d_ready"}, 32'(bus.d_ready), 32'h0);
    chk({tag, ".i_dataout"}, bus.i_dataout, 32'h0);
    chk({tag, ".d_dataout"}, bus.d_dataout, 32'h0);
    chk({tag, ".mem_ren"}, 32'(bus.mem_ren), 32'h0);
    chk({tag, ".mem_wen"}, 32'(bus.mem_wen), 32'h0);
    chk({tag, ".mem_address"}, bus.mem_address, 32'h0);
    chk({tag, ".mem_datain"}, bus.mem_datain, 32'h0);
    chk({tag, ".mem_bsel"}, 32'(bus.mem_byte_select), 32'h0);
    chk({tag, ".err"}, 32'(err), 32'h0);
  endtask

  logic [31:0] exp_d_data;
  logic [31:0] exp_i_data;
  logic        exp_side_d;
  logic [31:0] rd;

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    bus.i_ren = 1'b0; bus.i_address = '0;
    bus.d_ren = 1'b0; bus.d_wen = 1'b0; bus.d_address = '0;
    bus.d_datain = '0; bus.d_byte_select = 4'h0;
    bus.mem_dataout = '0; bus.mem_memsig = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // I-only read, completion three cycles after the grant
    bus.i_ren = 1'b1; bus.i_address = 32'h40;
    tick();
    chk("i_rd.mem_ren", 32'(bus.mem_ren), 32'h1);
    chk("i_rd.mem_wen", 32'(bus.mem_wen), 32'h0);
    chk("i_rd.mem_addr", bus.mem_address, 32'h40);
    chk("i_rd.mem_bsel", 32'(bus.mem_byte_select), 32'hF);
    tick();
    chk("i_rd.wait_ready", 32'(bus.i_ready), 32'h0);
    tick();
    bus.mem_memsig = 1'b1; bus.mem_dataout = 32'hDEADBEEF;
    tick();
    chk("i_rd.i_ready", 32'(bus.i_ready), 32'h1);
    chk("i_rd.d_ready", 32'(bus.d_ready), 32'h0);
    chk("i_rd.i_dataout", bus.i_dataout, 32'hDEADBEEF);
    chk("i_rd.mem_ren_drop", 32'(bus.mem_ren), 32'h0);
    bus.mem_memsig = 1'b0; bus.i_ren = 1'b0;
    tick();
    chk("i_rd.pulse_end", 32'(bus.i_ready), 32'h0);
    chk("i_rd.data_held", bus.i_dataout, 32'hDEADBEEF);
    exp_i_data = 32'hDEADBEEF;
    tick();

    // Fresh reset, then both sides held: D, I, D, I
    reset = 1'b0; #1; reset = 1'b1;
    exp_i_data = 32'h0; exp_d_data = 32'h0;
    tick();
    bus.i_ren = 1'b1; bus.i_address = 32'h100;
    bus.d_ren = 1'b1; bus.d_address = 32'h200; bus.d_byte_select = 4'hC;
    for (int n = 0; n < 4; n++) begin
      exp_side_d = (n % 2 == 0);
      rd = 32'hA000_0000 + 32'(n);
      tick();
      chk("rr.grant_ren", 32'(bus.mem_ren), 32'h1);
      chk("rr.grant_addr", bus.mem_address, exp_side_d ? 32'h200 : 32'h100);
      chk("rr.grant_bsel", 32'(bus.mem_byte_select), exp_side_d ? 32'hC : 32'hF);
      tick();
      chk("rr.busy_no_ready", 32'(bus.i_ready | bus.d_ready), 32'h0);
      bus.mem_memsig = 1'b1; bus.mem_dataout = rd;
      tick();
      bus.mem_memsig = 1'b0;
      if (exp_side_d) exp_d_data = rd; else exp_i_data = rd;
      chk("rr.d_ready", 32'(bus.d_ready), 32'(exp_side_d));
      chk("rr.i_ready", 32'(bus.i_ready), 32'(!exp_side_d));
      chk("rr.d_dataout", bus.d_dataout, exp_d_data);
      chk("rr.i_dataout", bus.i_dataout, exp_i_data);
      tick();
      chk("rr.resp_no_ready", 32'(bus.i_ready | bus.d_ready), 32'h0);
      chk("rr.resp_no_grant", 32'(bus.mem_ren), 32'h0);
    end
    bus.i_ren = 1'b0; bus.d_ren = 1'b0;
    tick();

    // D write: wen wins over ren, read data untouched
    bus.d_wen = 1'b1; bus.d_ren = 1'b1; bus.d_address = 32'h300;
    bus.d_datain = 32'h12345678; bus.d_byte_select = 4'b0011;
    tick();
    chk("wr.mem_wen", 32'(bus.mem_wen), 32'h1);
    chk("wr.mem_ren", 32'(bus.mem_ren), 32'h0);
    chk("wr.mem_addr", bus.mem_address, 32'h300);
    chk("wr.mem_datain", bus.mem_datain, 32'h12345678);
    chk("wr.mem_bsel", 32'(bus.mem_byte_select), 32'h3);
    bus.mem_memsig = 1'b1; bus.mem_dataout = 32'hFFFF_FFFF;
    tick();
    chk("wr.d_ready", 32'(bus.d_ready), 32'h1);
    chk("wr.d_dataout_kept", bus.d_dataout, exp_d_data);
    chk("wr.mem_wen_drop", 32'(bus.mem_wen), 32'h0);
    bus.mem_memsig = 1'b0; bus.d_wen = 1'b0; bus.d_ren = 1'b0;
    tick();
    chk("wr.pulse_end", 32'(bus.d_ready), 32'h0);

    // Spurious memsig in IDLE, on the grant edge and in RESP
    bus.mem_memsig = 1'b1; bus.mem_dataout = 32'h5A5A_5A5A;
    tick();
    chk("spur.idle_ready", 32'(bus.i_ready | bus.d_ready), 32'h0);
    chk("spur.idle_cmd", 32'(bus.mem_ren | bus.mem_wen), 32'h0);
    bus.i_ren = 1'b1; bus.i_address = 32'h44;
    tick();
    chk("spur.grant_edge_ready", 32'(bus.i_ready), 32'h0);
    chk("spur.grant_edge_ren", 32'(bus.mem_ren), 32'h1);
    tick();
    chk("spur.i_ready", 32'(bus.i_ready), 32'h1);
    chk("spur.i_dataout", bus.i_dataout, 32'h5A5A_5A5A);
    bus.i_ren = 1'b0; bus.mem_dataout = 32'h1111_2222;
    tick();
    chk("spur.resp_ready", 32'(bus.i_ready | bus.d_ready), 32'h0);
    chk("spur.resp_data", bus.i_dataout, 32'h5A5A_5A5A);
    tick();
    chk("spur.idle2_ready", 32'(bus.i_ready | bus.d_ready), 32'h0);
    chk("spur.idle2_cmd", 32'(bus.mem_ren), 32'h0);
    bus.mem_memsig = 1'b0;
    tick();

    // Reset two cycles into BUSY_D drops everything; D wins tie afterwards
    bus.i_ren = 1'b1; bus.i_address = 32'h500;
    bus.d_ren = 1'b1; bus.d_address = 32'h400; bus.d_byte_select = 4'hF;
    tick();
    chk("rst.grant_addr", bus.mem_address, 32'h400);
    tick(); tick();
    reset = 1'b0;
    #1;
    check_all_zero("rst_async");
    tick();
    reset = 1'b1;
    tick();
    chk("rst.regrant_ren", 32'(bus.mem_ren), 32'h1);
    chk("rst.regrant_addr", bus.mem_address, 32'h400);
    chk("rst.no_d_ready", 32'(bus.d_ready), 32'h0);
    bus.mem_memsig = 1'b1; bus.mem_dataout = 32'hCAFE_F00D;
    tick();
    chk("rst.d_ready", 32'(bus.d_ready), 32'h1);
    chk("rst.d_dataout", bus.d_dataout, 32'hCAFE_F00D);
    bus.mem_memsig = 1'b0; bus.i_ren = 1'b0; bus.d_ren = 1'b0;
    tick(); tick();

`ifdef ARB_TIMEOUT_EN
    // Watchdog: D read never completes
    bus.d_ren = 1'b1; bus.d_address = 32'h600;
    tick();
    chk("to.grant_ren", 32'(bus.mem_ren), 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("to.wait_ready", 32'(bus.d_ready), 32'h0);
      chk("to.wait_ren", 32'(bus.mem_ren), 32'h1);
    end
    tick();
    chk("to.d_ready", 32'(bus.d_ready), 32'h1);
    chk("to.err", 32'(err), 32'h1);
    chk("to.mem_ren_drop", 32'(bus.mem_ren), 32'h0);
    chk("to.d_dataout_kept", bus.d_dataout, 32'hCAFE_F00D);
    bus.d_ren = 1'b0;
    tick();
    chk("to.pulse_end_ready", 32'(bus.d_ready), 32'h0);
    chk("to.pulse_end_err", 32'(err), 32'h0);
    tick();
    chk("to.idle_ren", 32'(bus.mem_ren), 32'h0);
`else
    chk("err_tied", 32'(err), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
